param_data_memory: RTL and testbench

Parametrised, byte-addressed, single-port data memory that succeeds the fixed 16-bit × 256 data memory in the Harvard datapath. It adds configurable width and depth, per-byte write enables, and a valid/ready request/response handshake with a registered read (1-cycle latency). It also adds a hardware zero-fill sequencer that replaces simulation-only initialisation, plus an error response for misaligned or out-of-range accesses. It sits between the core's MEM stage and the data-side address decode.

---
 rtl/mem_pkg.sv | 17 +
 rtl/bytelane_ram.sv | 38 +++
 rtl/param_data_memory.sv | 123 ++++++++++++
 tb/tb_param_data_memory.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the parametrised data memory.
package mem_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 256;

    // Number of byte-offset address bits inside one word.
    function automatic int calc_off(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/bytelane_ram.sv
// Byte-lane RAM: one 8-bit array per lane, synchronous per-lane write and registered read.
module bytelane_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int IW     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic [DATA_W/8-1:0] we,
    input  logic [IW-1:0]       widx,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                re,
    input  logic [IW-1:0]       ridx,
    output logic [DATA_W-1:0]   rdata
);

    localparam int NB = DATA_W / 8;

    for (genvar i = 0; i < NB; i++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] q;

        always_ff @(posedge clk) begin
            if (we[i]) begin
                mem[widx] <= wdata[8*i +: 8];
            end
        end

        // Read register only moves on a read, so the value holds while a response stalls.
        always_ff @(posedge clk) begin
            if (re) begin
                q <= mem[ridx];
            end
        end

        assign rdata[8*i +: 8] = q;
    end

endmodule

// File: rtl/param_data_memory.sv
// Single-port byte-addressed data memory with zero-fill sequencer,
// valid/ready request/response handshake and error responses.
module param_data_memory
    import mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_done,
    output logic                state_dbg
);

    // Handshake: a request transfers on an edge where req_valid && req_ready,
    // a response transfers on an edge where rsp_valid && rsp_ready.

    localparam int NB       = DATA_W / 8;
    localparam int OFF      = calc_off(DATA_W);
    localparam int IW       = $clog2(DEPTH);
    localparam int LOW_BITS = OFF + IW;
    localparam logic [ADDR_W-1:0] HI_MASK = {ADDR_W{1'b1}} << LOW_BITS;

    state_t        state;
    logic [IW-1:0] init_cnt;
    logic          rsp_rd;

    logic [IW-1:0] idx;
    logic          misaligned;
    logic          out_of_range;
    logic          err;
    logic          accept;

    logic [NB-1:0]     ram_we;
    logic [IW-1:0]     ram_widx;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_re;
    logic [DATA_W-1:0] ram_q;

    assign idx          = req_addr[LOW_BITS-1:OFF];
    assign misaligned   = |req_addr[OFF-1:0];
    assign out_of_range = |(req_addr & HI_MASK);
    assign err          = misaligned | out_of_range;

    assign init_done = (state == RUN);
    assign state_dbg = state;
    assign req_ready = init_done && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;

    always_comb begin
        ram_we    = '0;
        ram_widx  = idx;
        ram_wdata = req_wdata;
        ram_re    = 1'b0;
        if (state == INIT) begin
            ram_we    = '1;
            ram_widx  = init_cnt;
            ram_wdata = '0;
        end else if (accept && !err) begin
            if (req_write) begin
                ram_we = req_be;
            end else begin
                ram_re = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
        end else if (state == INIT) begin
            if (init_cnt == IW'(DEPTH - 1)) begin
                state <= RUN;
            end else begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rd    <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_err   <= err;
            rsp_rd    <= !req_write && !err;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Read data lives in the RAM output register; writes and errors report zero.
    assign rsp_rdata = (rsp_valid && rsp_rd) ? ram_q : '0;

    bytelane_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IW     (IW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .widx  (ram_widx),
        .wdata (ram_wdata),
        .re    (ram_re),
        .ridx  (idx),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_param_data_memory.sv
// Directed bench for param_data_memory (16-bit x 256 default configuration).
module tb_param_data_memory;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;
    logic        state_dbg;

    int errors = 0;
    int checks = 0;
    int n;

    param_data_memory dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .init_done (init_done),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic w, input logic [15:0] a, input logic [15:0] d,
                             input logic [1:0] be);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
    endtask

    task automatic idle_req();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
    endtask

    // Counts edges from now until init_done rises, bounded.
    task automatic wait_init(output int cnt);
        cnt = 0;
        while (!init_done && cnt < 400) begin
            step();
            cnt++;
        end
    endtask

    // Single request with rsp_ready high, then check its response the cycle after acceptance.
    task automatic one_req(input string tag, input logic w, input logic [15:0] a,
                           input logic [15:0] d, input logic [1:0] be,
                           input logic [15:0] exp_rdata, input logic exp_err);
        drive_req(w, a, d, be);
        rsp_ready = 1'b1;
        chk_bit({tag, "_req_ready"}, req_ready, 1'b1);
        step();
        idle_req();
        chk_bit({tag, "_rsp_valid"}, rsp_valid, 1'b1);
        chk_word({tag, "_rdata"}, rsp_rdata, exp_rdata);
        chk_bit({tag, "_err"}, rsp_err, exp_err);
        step();
        chk_bit({tag, "_rsp_drop"}, rsp_valid, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b0;
        idle_req();
        #1;
        chk_bit("rst_req_ready", req_ready, 1'b0);
        chk_bit("rst_rsp_valid", rsp_valid, 1'b0);
        chk_word("rst_rsp_rdata", rsp_rdata, 16'h0000);
        chk_bit("rst_rsp_err", rsp_err, 1'b0);
        chk_bit("rst_init_done", init_done, 1'b0);
        chk_bit("rst_state", state_dbg, 1'b0);
        step();
        step();
        rst = 1'b0;
        wait_init(n);
        chk_int("init_edges", n, 256);
        chk_bit("init_state_run", state_dbg, 1'b1);

        one_req("rd_1fe", 1'b0, 16'h01FE, 16'h0000, 2'b00, 16'h0000, 1'b0);

        // Back-to-back write then read of the same word.
        rsp_ready = 1'b1;
        drive_req(1'b1, 16'h0010, 16'hBEEF, 2'b11);
        chk_bit("b2b_wr_ready", req_ready, 1'b1);
        step();
        drive_req(1'b0, 16'h0010, 16'h0000, 2'b00);
        chk_bit("b2b_wr_rsp_valid", rsp_valid, 1'b1);
        chk_word("b2b_wr_rdata", rsp_rdata, 16'h0000);
        chk_bit("b2b_rd_ready", req_ready, 1'b1);
        step();
        idle_req();
        chk_bit("b2b_rd_rsp_valid", rsp_valid, 1'b1);
        chk_word("b2b_rd_rdata", rsp_rdata, 16'hBEEF);
        chk_bit("b2b_rd_err", rsp_err, 1'b0);
        step();
        chk_bit("b2b_rsp_drop", rsp_valid, 1'b0);

        one_req("wr_lo", 1'b1, 16'h0010, 16'h12AB, 2'b01, 16'h0000, 1'b0);
        one_req("rd_merge", 1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEAB, 1'b0);
        one_req("wr_be0", 1'b1, 16'h0010, 16'h5555, 2'b00, 16'h0000, 1'b0);
        one_req("rd_be0", 1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEAB, 1'b0);
        one_req("wr_hi", 1'b1, 16'h01FE, 16'hA5C3, 2'b10, 16'h0000, 1'b0);
        one_req("rd_hi", 1'b0, 16'h01FE, 16'h0000, 2'b00, 16'hA500, 1'b0);

        one_req("rd_misalign", 1'b0, 16'h0011, 16'h0000, 2'b00, 16'h0000, 1'b1);
        one_req("rd_oor", 1'b0, 16'h0200, 16'h0000, 2'b00, 16'h0000, 1'b1);
        one_req("wr_oor", 1'b1, 16'h0200, 16'hFFFF, 2'b11, 16'h0000, 1'b1);
        one_req("rd_word0", 1'b0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 1'b0);
        one_req("rd_after_err", 1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEAB, 1'b0);

        // Stall: response held while rsp_ready is low; a new request waits.
        rsp_ready = 1'b0;
        drive_req(1'b0, 16'h0010, 16'h0000, 2'b00);
        step();
        drive_req(1'b0, 16'h0000, 16'h0000, 2'b00);
        for (int i = 0; i < 5; i++) begin
            chk_bit("stall_req_ready", req_ready, 1'b0);
            chk_bit("stall_rsp_valid", rsp_valid, 1'b1);
            chk_word("stall_rdata", rsp_rdata, 16'hBEAB);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk_bit("release_req_ready", req_ready, 1'b1);
        step();
        idle_req();
        chk_bit("release_rsp_valid", rsp_valid, 1'b1);
        chk_word("release_rdata", rsp_rdata, 16'h0000);
        step();
        chk_bit("release_rsp_drop", rsp_valid, 1'b0);

        // Reset in the middle of the zero-fill.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
        end
        chk_bit("mid_init_not_done", init_done, 1'b0);
        rst = 1'b1;
        #1;
        chk_bit("mid_init_rst_done", init_done, 1'b0);
        chk_bit("mid_init_rst_ready", req_ready, 1'b0);
        step();
        rst = 1'b0;
        wait_init(n);
        chk_int("reinit_edges", n, 256);

        // Reset with a response pending.
        rsp_ready = 1'b0;
        drive_req(1'b0, 16'h0010, 16'h0000, 2'b00);
        step();
        idle_req();
        chk_bit("pend_rsp_valid", rsp_valid, 1'b1);
        chk_word("pend_rdata_zeroed", rsp_rdata, 16'h0000);
        rst = 1'b1;
        #1;
        chk_bit("pend_rst_rsp_valid", rsp_valid, 1'b0);
        chk_bit("pend_rst_init_done", init_done, 1'b0);
        chk_bit("pend_rst_req_ready", req_ready, 1'b0);
        chk_bit("pend_rst_err", rsp_err, 1'b0);
        rst = 1'b0;
        wait_init(n);
        chk_int("second_release_edges", n, 256);

        one_req("rd_hi_after_fill", 1'b0, 16'h01FE, 16'h0000, 2'b00, 16'h0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
